pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 153 +++++++++++++++
 tb/tb_pwm_capture.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture
// Purpose  : Measures period and high time of an asynchronous PWM input and
//            exposes the results through a small register interface.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_capture (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [2:0]  address,
  input  logic [15:0] write_data_in,
  output logic [15:0] read_data_out,
  input  logic        pwm_in,
  output logic        capture_valid
);

  localparam logic [2:0]  c_addr_period  = 3'd0;
  localparam logic [2:0]  c_addr_high    = 3'd2;
  localparam logic [2:0]  c_addr_control = 3'd4;
  localparam logic [2:0]  c_addr_status  = 3'd6;
  localparam logic [15:0] c_cnt_max      = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_high_shadow;
  logic [15:0] r_period;
  logic [15:0] r_high;
  logic [15:0] r_control;
  logic        r_valid;
  logic        r_overflow;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync3;

  logic        w_rise;
  logic        w_fall;
  logic        w_cnt_max;
  logic [15:0] w_cnt_next;
  logic        w_status_rd;
  logic        w_enable;

  // Two-flop synchronizer followed by the edge-detect stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_rise      = r_sync2 & ~r_sync3;
  assign w_fall      = ~r_sync2 & r_sync3;
  assign w_cnt_max   = (r_cnt == c_cnt_max);
  assign w_cnt_next  = w_cnt_max ? r_cnt : r_cnt + 16'd1;
  assign w_status_rd = read_enable && (address == c_addr_status);
  assign w_enable    = r_control[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_control <= 16'h0000;
    end else if (write_enable && (address == c_addr_control)) begin
      r_control <= write_data_in;
    end
  end

  // Flag sets are placed after the clear so a same-cycle set wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= 16'h0000;
      r_high_shadow <= 16'h0000;
      r_period      <= 16'h0000;
      r_high        <= 16'h0000;
      r_valid       <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_status_rd) begin
        r_valid    <= 1'b0;
        r_overflow <= 1'b0;
      end
      if (!w_enable) begin
        r_state <= S_IDLE;
        r_cnt   <= 16'h0000;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_rise) begin
              r_cnt   <= 16'd1;
              r_state <= S_HIGH;
            end
          end
          S_HIGH: begin
            if (w_fall) begin
              r_high_shadow <= r_cnt;
              r_cnt         <= w_cnt_next;
              r_state       <= S_LOW;
            end else if (w_cnt_max) begin
              r_overflow <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_cnt <= w_cnt_next;
            end
          end
          S_LOW: begin
            if (w_rise) begin
              r_period <= r_cnt;
              r_high   <= r_high_shadow;
              r_valid  <= 1'b1;
              r_cnt    <= 16'd1;
              r_state  <= S_HIGH;
            end else if (w_cnt_max) begin
              r_overflow <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_cnt <= w_cnt_next;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    read_data_out = 16'h0000;
    if (read_enable) begin
      case (address)
        c_addr_period:  read_data_out = r_period;
        c_addr_high:    read_data_out = r_high;
        c_addr_control: read_data_out = r_control;
        c_addr_status:  read_data_out = {14'b0, r_overflow, r_valid};
        default:        read_data_out = 16'h0000;
      endcase
    end
  end

  assign capture_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module   : tb_pwm_capture
// Purpose  : Randomized self-checking bench for pwm_capture.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

  logic        clock = 1'b0;
  logic        reset;
  logic        write_enable;
  logic        read_enable;
  logic [2:0]  address;
  logic [15:0] write_data_in;
  logic [15:0] read_data_out;
  logic        pwm_in;
  logic        capture_valid;

  int checks = 0;
  int errors = 0;

  // Expected register contents, derived from the pulse widths driven on the pin.
  logic [15:0] exp_period;
  logic [15:0] exp_high;
  logic [15:0] exp_ctrl;

  pwm_capture dut (
    .clock         (clock),
    .reset         (reset),
    .write_enable  (write_enable),
    .read_enable   (read_enable),
    .address       (address),
    .write_data_in (write_data_in),
    .read_data_out (read_data_out),
    .pwm_in        (pwm_in),
    .capture_valid (capture_valid)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    address       = a;
    write_data_in = d;
    write_enable  = 1'b1;
    tick();
    write_enable  = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    address     = a;
    read_enable = 1'b1;
    #1;
    d = read_data_out;
    tick();
    read_enable = 1'b0;
  endtask

  task automatic pulse(input int h, input int l);
    pwm_in = 1'b1;
    wait_cycles(h);
    pwm_in = 1'b0;
    wait_cycles(l);
  endtask

  task automatic restart(input logic [15:0] ctrl);
    bus_write(3'd4, 16'h0000);
    bus_write(3'd4, ctrl);
    exp_ctrl = ctrl;
    wait_cycles(4);
  endtask

  task automatic test_reset();
    logic [2:0] a;
    reset = 1'b1; write_enable = 1'b0; read_enable = 1'b0;
    address = 3'd0; write_data_in = 16'h0000; pwm_in = 1'b0;
    wait_cycles(3);
    for (int i = 0; i < 8; i++) begin
      a = 3'(i);
      address = a; read_enable = 1'b1; #1;
      checks++;
      if (read_data_out !== 16'h0000) begin
        errors++;
        $display("FAIL reset_read addr=%0d got=%h exp=%h", a, read_data_out, 16'h0000);
      end
    end
    read_enable = 1'b0;
    checks++;
    if (capture_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_capture_valid got=%b exp=0", capture_valid);
    end
    tick();
    reset = 1'b0;
    exp_period = 16'h0; exp_high = 16'h0; exp_ctrl = 16'h0;
    wait_cycles(2);
  endtask

  task automatic test_capture_basic();
    logic [15:0] d;
    bus_write(3'd4, 16'h0001);
    exp_ctrl = 16'h0001;
    wait_cycles(4);
    pulse(30, 70);
    pwm_in = 1'b1;
    wait_cycles(5);
    exp_period = 16'd100; exp_high = 16'd30;
    checks++;
    if (capture_valid !== 1'b1) begin
      errors++; $display("FAIL basic_valid got=%b exp=1", capture_valid);
    end
    bus_read(3'd0, d);
    checks++;
    if (d !== exp_period) begin errors++; $display("FAIL basic_period got=%h exp=%h", d, exp_period); end
    bus_read(3'd2, d);
    checks++;
    if (d !== exp_high) begin errors++; $display("FAIL basic_high got=%h exp=%h", d, exp_high); end
    bus_read(3'd6, d);
    checks++;
    if (d !== 16'h0001) begin errors++; $display("FAIL basic_status got=%h exp=0001", d); end
    bus_read(3'd6, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL basic_status_cleared got=%h exp=0000", d); end
    pwm_in = 1'b0;
    wait_cycles(20);
  endtask

  task automatic test_random_capture();
    logic [15:0] d;
    logic [15:0] ctrl;
    int h1, l1, h2, l2;
    for (int it = 0; it < 6; it++) begin
      ctrl = 16'($urandom()) | 16'h0001;
      restart(ctrl);
      h1 = $urandom_range(60, 1); l1 = $urandom_range(60, 1);
      h2 = $urandom_range(60, 1); l2 = $urandom_range(60, 1);
      pulse(h1, l1);
      pulse(h2, l2);
      pwm_in = 1'b1;
      wait_cycles(5);
      exp_period = 16'(h2 + l2);
      exp_high   = 16'(h2);
      checks++;
      if (capture_valid !== 1'b1) begin
        errors++; $display("FAIL rand_valid it=%0d got=%b exp=1", it, capture_valid);
      end
      bus_read(3'd0, d);
      checks++;
      if (d !== exp_period) begin errors++; $display("FAIL rand_period it=%0d got=%h exp=%h", it, d, exp_period); end
      bus_read(3'd2, d);
      checks++;
      if (d !== exp_high) begin errors++; $display("FAIL rand_high it=%0d got=%h exp=%h", it, d, exp_high); end
      bus_read(3'd4, d);
      checks++;
      if (d !== exp_ctrl) begin errors++; $display("FAIL rand_control it=%0d got=%h exp=%h", it, d, exp_ctrl); end
      bus_read(3'd6, d);
      checks++;
      if (d !== 16'h0001) begin errors++; $display("FAIL rand_status it=%0d got=%h exp=0001", it, d); end
      pwm_in = 1'b0;
      wait_cycles(5);
    end
  endtask

  task automatic test_disable_abort();
    logic [15:0] d;
    restart(16'h0001);
    pulse(30, 70);
    pwm_in = 1'b1;
    wait_cycles(10);
    exp_period = 16'd100; exp_high = 16'd30;
    bus_read(3'd6, d);
    bus_write(3'd4, 16'h0000);
    exp_ctrl = 16'h0000;
    wait_cycles(15);
    pwm_in = 1'b0;
    wait_cycles(10);
    pulse(10, 40);
    pulse(10, 40);
    pwm_in = 1'b1;
    wait_cycles(5);
    bus_read(3'd0, d);
    checks++;
    if (d !== exp_period) begin errors++; $display("FAIL abort_period got=%h exp=%h", d, exp_period); end
    bus_read(3'd2, d);
    checks++;
    if (d !== exp_high) begin errors++; $display("FAIL abort_high got=%h exp=%h", d, exp_high); end
    checks++;
    if (capture_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got=%b exp=0", capture_valid); end
    pwm_in = 1'b0;
    wait_cycles(5);
  endtask

  task automatic test_reg_access();
    logic [15:0] d;
    logic [2:0] a;
    for (int i = 0; i < 8; i++) begin
      a = 3'(i);
      if (a != 3'd4) bus_write(a, 16'h1234);
    end
    bus_read(3'd0, d);
    checks++;
    if (d !== exp_period) begin errors++; $display("FAIL ro_period got=%h exp=%h", d, exp_period); end
    bus_read(3'd2, d);
    checks++;
    if (d !== exp_high) begin errors++; $display("FAIL ro_high got=%h exp=%h", d, exp_high); end
    bus_read(3'd6, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL ro_status got=%h exp=0000", d); end
    bus_read(3'd4, d);
    checks++;
    if (d !== exp_ctrl) begin errors++; $display("FAIL ignored_write_control got=%h exp=%h", d, exp_ctrl); end
    bus_write(3'd4, 16'hABCD);
    exp_ctrl = 16'hABCD;
    bus_read(3'd4, d);
    checks++;
    if (d !== exp_ctrl) begin errors++; $display("FAIL control_rw got=%h exp=%h", d, exp_ctrl); end
    bus_read(3'd5, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL odd_read got=%h exp=0000", d); end
    address = 3'd4; read_enable = 1'b0; #1;
    checks++;
    if (read_data_out !== 16'h0000) begin
      errors++; $display("FAIL idle_read got=%h exp=0000", read_data_out);
    end
    // simultaneous write and read of CONTROL: read returns the old value
    write_data_in = 16'h5A5A; write_enable = 1'b1; read_enable = 1'b1; #1;
    d = read_data_out;
    tick();
    write_enable = 1'b0; read_enable = 1'b0;
    checks++;
    if (d !== exp_ctrl) begin errors++; $display("FAIL rw_same_cycle_old got=%h exp=%h", d, exp_ctrl); end
    exp_ctrl = 16'h5A5A;
    bus_read(3'd4, d);
    checks++;
    if (d !== exp_ctrl) begin errors++; $display("FAIL rw_same_cycle_new got=%h exp=%h", d, exp_ctrl); end
  endtask

  task automatic test_set_wins();
    logic [15:0] d;
    restart(16'h0001);
    bus_read(3'd6, d);
    pulse(20, 40);
    pwm_in = 1'b1;
    wait_cycles(2);
    // the rise pulse is being acted on at the next edge; read STATUS in that cycle
    address = 3'd6; read_enable = 1'b1; #1;
    d = read_data_out;
    tick();
    read_enable = 1'b0;
    exp_period = 16'd60; exp_high = 16'd20;
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL setwin_preread got=%h exp=0000", d); end
    checks++;
    if (capture_valid !== 1'b1) begin errors++; $display("FAIL setwin_valid got=%b exp=1", capture_valid); end
    bus_read(3'd0, d);
    checks++;
    if (d !== exp_period) begin errors++; $display("FAIL setwin_period got=%h exp=%h", d, exp_period); end
    pwm_in = 1'b0;
    wait_cycles(5);
  endtask

  task automatic test_overflow();
    logic [15:0] d;
    restart(16'h0001);
    bus_read(3'd6, d);
    pwm_in = 1'b1;
    wait_cycles(65530);
    bus_read(3'd6, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL ovf_early got=%h exp=0000", d); end
    wait_cycles(20);
    bus_read(3'd6, d);
    checks++;
    if (d !== 16'h0002) begin errors++; $display("FAIL ovf_status got=%h exp=0002", d); end
    bus_read(3'd0, d);
    checks++;
    if (d !== exp_period) begin errors++; $display("FAIL ovf_period got=%h exp=%h", d, exp_period); end
    bus_read(3'd2, d);
    checks++;
    if (d !== exp_high) begin errors++; $display("FAIL ovf_high got=%h exp=%h", d, exp_high); end
    // after overflow the block waits in IDLE for the next rise
    pwm_in = 1'b0;
    wait_cycles(5);
    pulse(10, 20);
    pwm_in = 1'b1;
    wait_cycles(5);
    exp_period = 16'd30; exp_high = 16'd10;
    bus_read(3'd0, d);
    checks++;
    if (d !== exp_period) begin errors++; $display("FAIL ovf_restart_period got=%h exp=%h", d, exp_period); end
    bus_read(3'd2, d);
    checks++;
    if (d !== exp_high) begin errors++; $display("FAIL ovf_restart_high got=%h exp=%h", d, exp_high); end
  endtask

  task automatic test_async_reset();
    logic [15:0] d;
    logic [2:0] a;
    pwm_in = 1'b0;
    wait_cycles(10);
    #1 reset = 1'b1;
    #0.5;
    checks++;
    if (capture_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%b exp=0", capture_valid); end
    read_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 3'(2 * i);
      address = a;
      #0.5;
      checks++;
      if (read_data_out !== 16'h0000) begin
        errors++; $display("FAIL areset_read addr=%0d got=%h exp=0000", a, read_data_out);
      end
    end
    read_enable = 1'b0;
    tick();
    reset = 1'b0;
    exp_period = 16'h0; exp_high = 16'h0; exp_ctrl = 16'h0;
    pulse(20, 30);
    pulse(20, 30);
    pwm_in = 1'b1;
    wait_cycles(5);
    bus_read(3'd0, d);
    checks++;
    if (d !== exp_period) begin errors++; $display("FAIL post_reset_period got=%h exp=%h", d, exp_period); end
    checks++;
    if (capture_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got=%b exp=0", capture_valid); end
    bus_write(3'd4, 16'h0001);
    pwm_in = 1'b0;
    wait_cycles(5);
    pulse(15, 25);
    pwm_in = 1'b1;
    wait_cycles(5);
    exp_period = 16'd40; exp_high = 16'd15;
    bus_read(3'd0, d);
    checks++;
    if (d !== exp_period) begin errors++; $display("FAIL reenable_period got=%h exp=%h", d, exp_period); end
    bus_read(3'd2, d);
    checks++;
    if (d !== exp_high) begin errors++; $display("FAIL reenable_high got=%h exp=%h", d, exp_high); end
    pwm_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_capture_basic();
    test_random_capture();
    test_disable_abort();
    test_reg_access();
    test_set_wins();
    test_overflow();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
